vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator; the next generation of the fixed 640x480 sync block.
- Derives a pixel-rate enable from the system clock and runs horizontal and vertical counters with configurable porch, sync and active lengths.
- Emits registered hsync, vsync, video_on and pixel coordinates, all aligned to each other, plus pixel, line and frame strobes for the pixel generator.
- Sits between the system clock and the pixel/colour logic that drives the VGA pins.

---
 rtl/vga_timing_gen_pkg.sv | 47 ++++
 rtl/vga_timing_gen_pix_clk_en.sv | 33 +++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and elaboration-time helpers for the raster generator.
package vga_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FRONT  = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BACK   = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FRONT  = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BACK   = 33;
    localparam int unsigned DEF_CLK_DIV  = 4;
    localparam int unsigned DEF_CW       = 10;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned sync_start(input int unsigned active, input int unsigned front);
        return active + front;
    endfunction

    // Exclusive end of the sync window.
    function automatic int unsigned sync_end(input int unsigned active, input int unsigned front,
                                             input int unsigned sync);
        return active + front + sync;
    endfunction

    // Bits needed to hold the values 0..count-1 (never less than one bit).
    function automatic int unsigned width_for(input int unsigned count);
        return (count <= 2) ? 1 : $clog2(count);
    endfunction

    localparam int unsigned DEF_H_TOTAL  = h_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL  = v_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
    localparam int unsigned DEF_HS_START = sync_start(DEF_H_ACTIVE, DEF_H_FRONT);
    localparam int unsigned DEF_HS_END   = sync_end(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC);
    localparam int unsigned DEF_VS_START = sync_start(DEF_V_ACTIVE, DEF_V_FRONT);
    localparam int unsigned DEF_VS_END   = sync_end(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC);

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel-rate enable: divides clk by CLK_DIV while en is high, holding its phase while en is low.
module pix_clk_en
    import vga_timing_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned   DW   = width_for(CLK_DIV);
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("pix_clk_en: CLK_DIV must be at least 1");
    end

    logic [DW-1:0] div;

    // With CLK_DIV=1 the divider is pinned at 0 == LAST, so tick simply follows en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
        end else if (en) begin
            div <= (div == LAST) ? '0 : div + 1'b1;
        end
    end

    assign tick = en && (div == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: pixel enable, h/v counters and aligned registered outputs.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FRONT  = DEF_H_FRONT,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BACK   = DEF_H_BACK,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FRONT  = DEF_V_FRONT,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BACK   = DEF_V_BACK,
    parameter int unsigned CLK_DIV  = DEF_CLK_DIV,
    parameter logic        HS_POL   = 1'b0,
    parameter logic        VS_POL   = 1'b0,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          pix_tick,
    output logic          line_start,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic [CW-1:0] px,
    output logic [CW-1:0] py
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

    if (64'(H_TOTAL) > (64'd1 << CW)) begin : g_bad_h
        $error("vga_timing_gen: H_TOTAL does not fit in CW bits");
    end
    if (64'(V_TOTAL) > (64'd1 << CW)) begin : g_bad_v
        $error("vga_timing_gen: V_TOTAL does not fit in CW bits");
    end

    // Inclusive bounds keep every comparison inside CW bits even when a total equals 2^CW.
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] HA_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] VA_LAST  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HS_FIRST = CW'(sync_start(H_ACTIVE, H_FRONT));
    localparam logic [CW-1:0] HS_LAST  = CW'(sync_end(H_ACTIVE, H_FRONT, H_SYNC) - 1);
    localparam logic [CW-1:0] VS_FIRST = CW'(sync_start(V_ACTIVE, V_FRONT));
    localparam logic [CW-1:0] VS_LAST  = CW'(sync_end(V_ACTIVE, V_FRONT, V_SYNC) - 1);

    logic          adv;
    logic          h_wrap;
    logic [CW-1:0] nx;
    logic [CW-1:0] ny;
    logic          hs_win;
    logic          vs_win;
    logic          vis;

    pix_clk_en #(
        .CLK_DIV(CLK_DIV)
    ) u_pix_clk_en (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(adv)
    );

    // Qualifiers are decoded from the next coordinates so they register alongside px/py.
    always_comb begin
        h_wrap = (px == H_LAST);
        nx     = h_wrap ? '0 : px + 1'b1;
        ny     = py;
        if (h_wrap) begin
            ny = (py == V_LAST) ? '0 : py + 1'b1;
        end
        hs_win = (nx >= HS_FIRST) && (nx <= HS_LAST);
        vs_win = (ny >= VS_FIRST) && (ny <= VS_LAST);
        vis    = (nx <= HA_LAST) && (ny <= VA_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px          <= H_LAST;
            py          <= V_LAST;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            video_on    <= 1'b0;
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (adv) begin
            px          <= nx;
            py          <= ny;
            hsync       <= hs_win ? HS_POL : ~HS_POL;
            vsync       <= vs_win ? VS_POL : ~VS_POL;
            video_on    <= vis;
            pix_tick    <= 1'b1;
            line_start  <= (nx == '0);
            frame_start <= (nx == '0) && (ny == '0);
        end else begin
            pix_tick    <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: four generator configurations against a frame-index reference model.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        int div;
        bit hp; bit vp;
    } cfg_t;

    localparam cfg_t C0 = '{ha:640, hf:16, hs:96,  hb:48, va:480, vf:10, vs:2, vb:33, div:4, hp:1'b0, vp:1'b0};
    localparam cfg_t C1 = '{ha:8,   hf:2,  hs:3,   hb:2,  va:6,   vf:1,  vs:2, vb:2,  div:3, hp:1'b0, vp:1'b1};
    localparam cfg_t C2 = '{ha:10,  hf:2,  hs:3,   hb:1,  va:5,   vf:1,  vs:1, vb:1,  div:1, hp:1'b1, vp:1'b0};
    localparam cfg_t C3 = '{ha:800, hf:40, hs:128, hb:88, va:600, vf:1,  vs:4, vb:23, div:1, hp:1'b1, vp:1'b1};

    function automatic cfg_t cfg_of(input int i);
        case (i)
            0:       return C0;
            1:       return C1;
            2:       return C2;
            default: return C3;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst [4];
    logic en  [4];
    logic tk [4], ls [4], fs [4], hs [4], vs [4], vo [4];
    logic [9:0]  px0, py0;
    logic [3:0]  px1, py1, px2, py2;
    logic [10:0] px3, py3;
    int apx [4];
    int apy [4];

    int checks = 0;
    int errors = 0;
    bit done_script = 0, done_rand = 0, done_u3 = 0;

    always #5 clk = ~clk;

    vga_timing_gen u0 (
        .clk(clk), .rst(rst[0]), .en(en[0]), .pix_tick(tk[0]), .line_start(ls[0]), .frame_start(fs[0]),
        .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]), .px(px0), .py(py0));

    vga_timing_gen #(
        .H_ACTIVE(C1.ha), .H_FRONT(C1.hf), .H_SYNC(C1.hs), .H_BACK(C1.hb),
        .V_ACTIVE(C1.va), .V_FRONT(C1.vf), .V_SYNC(C1.vs), .V_BACK(C1.vb),
        .CLK_DIV(C1.div), .HS_POL(1'b0), .VS_POL(1'b1), .CW(4)
    ) u1 (
        .clk(clk), .rst(rst[1]), .en(en[1]), .pix_tick(tk[1]), .line_start(ls[1]), .frame_start(fs[1]),
        .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]), .px(px1), .py(py1));

    vga_timing_gen #(
        .H_ACTIVE(C2.ha), .H_FRONT(C2.hf), .H_SYNC(C2.hs), .H_BACK(C2.hb),
        .V_ACTIVE(C2.va), .V_FRONT(C2.vf), .V_SYNC(C2.vs), .V_BACK(C2.vb),
        .CLK_DIV(C2.div), .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
    ) u2 (
        .clk(clk), .rst(rst[2]), .en(en[2]), .pix_tick(tk[2]), .line_start(ls[2]), .frame_start(fs[2]),
        .hsync(hs[2]), .vsync(vs[2]), .video_on(vo[2]), .px(px2), .py(py2));

    vga_timing_gen #(
        .H_ACTIVE(C3.ha), .H_FRONT(C3.hf), .H_SYNC(C3.hs), .H_BACK(C3.hb),
        .V_ACTIVE(C3.va), .V_FRONT(C3.vf), .V_SYNC(C3.vs), .V_BACK(C3.vb),
        .CLK_DIV(C3.div), .HS_POL(1'b1), .VS_POL(1'b1), .CW(11)
    ) u3 (
        .clk(clk), .rst(rst[3]), .en(en[3]), .pix_tick(tk[3]), .line_start(ls[3]), .frame_start(fs[3]),
        .hsync(hs[3]), .vsync(vs[3]), .video_on(vo[3]), .px(px3), .py(py3));

    always_comb begin
        apx[0] = int'(px0); apy[0] = int'(py0);
        apx[1] = int'(px1); apy[1] = int'(py1);
        apx[2] = int'(px2); apy[2] = int'(py2);
        apx[3] = int'(px3); apy[3] = int'(py3);
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_u(input int i, input string f, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL u%0d.%s: got %0d expected %0d at %0t", i, f, act, exp, $time);
        end
    endtask

    // Model: each instance is a position k in the linear frame 0..HT*VT-1, advanced once every
    // div enabled clocks counted since reset.
    int m_k   [4];
    int m_cnt [4];
    bit m_adv [4];

    always @(posedge clk) begin
        cfg_t c;
        int   n;
        int   cnt;
        for (int i = 0; i < 4; i++) begin
            c = cfg_of(i);
            n = (c.ha + c.hf + c.hs + c.hb) * (c.va + c.vf + c.vs + c.vb);
            if (rst[i]) begin
                m_cnt[i] <= 0;
                m_k[i]   <= n - 1;
                m_adv[i] <= 1'b0;
            end else if (en[i]) begin
                cnt = (m_cnt[i] + 1) % c.div;
                m_cnt[i] <= cnt;
                m_adv[i] <= (cnt == 0);
                if (cnt == 0) m_k[i] <= (m_k[i] + 1) % n;
            end else begin
                m_adv[i] <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        cfg_t c;
        int ht, vt, k, ex, ey;
        bit a, e_hs, e_vs, e_vo;
        for (int i = 0; i < 4; i++) begin
            c  = cfg_of(i);
            ht = c.ha + c.hf + c.hs + c.hb;
            vt = c.va + c.vf + c.vs + c.vb;
            if (rst[i]) begin
                k = ht * vt - 1;
                a = 1'b0;
            end else begin
                k = m_k[i];
                a = m_adv[i];
            end
            ex   = k % ht;
            ey   = k / ht;
            e_vo = (ex < c.ha) && (ey < c.va);
            e_hs = (ex >= c.ha + c.hf && ex < c.ha + c.hf + c.hs) ? c.hp : !c.hp;
            e_vs = (ey >= c.va + c.vf && ey < c.va + c.vf + c.vs) ? c.vp : !c.vp;
            check_u(i, "px", apx[i], ex);
            check_u(i, "py", apy[i], ey);
            check_u(i, "video_on", vo[i], e_vo);
            check_u(i, "hsync", hs[i], e_hs);
            check_u(i, "vsync", vs[i], e_vs);
            check_u(i, "pix_tick", tk[i], a);
            check_u(i, "line_start", ls[i], a && ex == 0);
            check_u(i, "frame_start", fs[i], a && k == 0);
        end
    end

    // u0 (defaults): reset values, first-tick latency, en freeze, asynchronous mid-line reset.
    initial begin : p_script
        int n;
        bit found;
        rst[0] = 1'b1; en[0] = 1'b1;
        rst[3] = 1'b1; en[3] = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst px0", px0, 799);
        check("rst py0", py0, 524);
        check("rst hsync0", hs[0], 1);
        check("rst vsync0", vs[0], 1);
        check("rst video_on0", vo[0], 0);
        check("rst strobes0", {tk[0], ls[0], fs[0]}, 0);
        check("rst px3 (H_TOTAL-1)", px3, 1055);
        check("rst py3 (V_TOTAL-1)", py3, 627);
        check("rst hsync3", hs[3], 0);
        check("rst vsync3", vs[3], 0);
        @(posedge clk); #2;
        rst[0] = 1'b0; rst[3] = 1'b0;

        n = 0; found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(posedge clk); n++; #1;
            if (tk[0]) found = 1;
        end
        check("first tick latency", found ? n : -1, 4);
        check("first px", px0, 0);
        check("first py", py0, 0);
        check("first frame_start", fs[0], 1);
        check("first line_start", ls[0], 1);
        check("first video_on", vo[0], 1);

        found = 0;
        for (int j = 0; j < 5000 && !found; j++) begin
            @(negedge clk);
            if (tk[0] && apx[0] == 300) found = 1;
        end
        check("reach px300", found, 1);
        @(posedge clk); #2;
        en[0] = 1'b0;
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            check("frozen px", px0, 300);
            check("frozen strobe", tk[0] | ls[0] | fs[0], 0);
        end
        @(posedge clk); #2;
        en[0] = 1'b1;
        n = 0; found = 0;
        for (int j = 0; j < 20 && !found; j++) begin
            @(posedge clk); n++; #1;
            if (apx[0] == 301) found = 1;
        end
        check("resume latency", found ? n : -1, 3);

        found = 0;
        for (int j = 0; j < 5000 && !found; j++) begin
            @(negedge clk);
            if (tk[0] && apx[0] == 300 && apy[0] == 1) found = 1;
        end
        check("reach px300 py1", found, 1);
        @(posedge clk); #2;
        rst[0] = 1'b1;
        #1;
        check("async rst px", px0, 799);
        check("async rst py", py0, 524);
        check("async rst hsync", hs[0], 1);
        check("async rst video_on", vo[0], 0);
        repeat (3) @(posedge clk);
        #2;
        rst[0] = 1'b0;
        repeat (20) @(posedge clk);
        done_script = 1;
    end

    // u3 (800x600, active-high syncs): hsync window over the first line and the line wrap.
    initial begin : p_u3
        int cnt, first, last;
        bit found;
        wait (rst[3] == 1'b0);
        found = 0;
        for (int j = 0; j < 50 && !found; j++) begin
            @(negedge clk);
            if (ls[3]) found = 1;
        end
        check("u3 first line_start", found, 1);
        cnt = 0; first = -1; last = -1;
        for (int j = 0; j < 1056; j++) begin
            if (hs[3]) begin
                cnt++;
                if (first < 0) first = apx[3];
                last = apx[3];
            end
            @(negedge clk);
        end
        check("u3 hsync ticks", cnt, 128);
        check("u3 hsync first px", first, 840);
        check("u3 hsync last px", last, 967);
        check("u3 wrap line_start", ls[3], 1);
        check("u3 wrap px", px3, 0);
        check("u3 wrap py", py3, 1);
        done_u3 = 1;
    end

    // u1/u2: frame-level counts, then randomized enable and reset traffic.
    initial begin : p_rand
        int clks, vcnt, hcnt, lcnt, tcnt;
        bit found;
        rst[1] = 1'b1; en[1] = 1'b1;
        rst[2] = 1'b1; en[2] = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst[1] = 1'b0; rst[2] = 1'b0;

        @(posedge clk);
        tcnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (tk[2]) tcnt++;
        end
        check("u2 tick every clk", tcnt, 40);

        found = 0;
        for (int j = 0; j < 1000 && !found; j++) begin
            @(negedge clk);
            if (fs[2]) found = 1;
        end
        check("u2 frame_start seen", found, 1);
        clks = 0;
        do begin
            @(negedge clk); clks++;
        end while (!fs[2] && clks < 1000);
        check("u2 clks per frame", clks, 128);

        found = 0;
        for (int j = 0; j < 2000 && !found; j++) begin
            @(negedge clk);
            if (fs[1]) found = 1;
        end
        check("u1 frame_start seen", found, 1);
        clks = 0; vcnt = 0; hcnt = 0; lcnt = 0;
        do begin
            if (tk[1] && vs[1]) vcnt++;
            if (tk[1] && !hs[1]) hcnt++;
            if (ls[1]) lcnt++;
            @(negedge clk); clks++;
        end while (!fs[1] && clks < 3000);
        check("u1 clks per frame", clks, 495);
        check("u1 vsync ticks", vcnt, 30);
        check("u1 hsync ticks", hcnt, 33);
        check("u1 lines per frame", lcnt, 11);

        for (int j = 0; j < 15000; j++) begin
            @(posedge clk); #2;
            en[1]  = ($urandom_range(0, 9) != 0);
            en[2]  = ($urandom_range(0, 3) != 0);
            rst[1] = ($urandom_range(0, 1999) == 0);
            rst[2] = ($urandom_range(0, 1999) == 0);
        end
        @(posedge clk); #2;
        rst[1] = 1'b0; rst[2] = 1'b0;
        done_rand = 1;
    end

    initial begin : p_main
        bit all_done;
        all_done = 0;
        for (int j = 0; j < 60000 && !all_done; j++) begin
            @(posedge clk);
            all_done = done_script && done_rand && done_u3;
        end
        check("all stimulus finished in budget", all_done, 1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
